// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with write bypass and per-register pending-write counters
module regfile_scoreboard #(
  parameter logic [63:0] STACK_TOP = 64'h0,
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        issue_valid,
  input  logic        issue_en_rd,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic        wb_en_rd,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        flush,
  output logic [63:0] a0,
  output logic [63:0] a1,
  output logic [63:0] a2,
  output logic [63:0] a3,
  output logic [63:0] a4,
  output logic [63:0] a5,
  output logic [63:0] a6,
  output logic [63:0] a7,
  output logic        pend_err
);
  localparam logic [PEND_W-1:0] ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  logic [63:0] x [32];
  logic [PEND_W-1:0] cnt [32];
  logic wr, iss;
  assign wr = wb_valid && wb_en_rd && wb_rd != 5'd0;
  assign issue_ready = !(issue_valid && issue_en_rd && issue_rd != 5'd0 && cnt[issue_rd] == '1 && !(wr && wb_rd == issue_rd));
  assign iss = issue_valid && issue_en_rd && issue_rd != 5'd0 && issue_ready;
  assign rs1_data = rs1_addr == 5'd0 ? 64'd0 : (wr && wb_rd == rs1_addr) ? wb_data : x[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? 64'd0 : (wr && wb_rd == rs2_addr) ? wb_data : x[rs2_addr];
  // a write retiring the last outstanding producer satisfies the read this cycle
  assign rs1_busy = rs1_addr != 5'd0 && cnt[rs1_addr] != '0 && !(wr && wb_rd == rs1_addr && cnt[rs1_addr] == ONE);
  assign rs2_busy = rs2_addr != 5'd0 && cnt[rs2_addr] != '0 && !(wr && wb_rd == rs2_addr && cnt[rs2_addr] == ONE);
  assign {a0, a1, a2, a3} = {x[10], x[11], x[12], x[13]};
  assign {a4, a5, a6, a7} = {x[14], x[15], x[16], x[17]};
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        x[i] <= i == 2 ? STACK_TOP : 64'd0;
        cnt[i] <= '0;
      end
      pend_err <= 1'b0;
    end else begin
      if (wr) x[wb_rd] <= wb_data;
      for (int i = 0; i < 32; i++)
        cnt[i] <= flush ? '0 : cnt[i] + {{(PEND_W-1){1'b0}}, iss && issue_rd == 5'(i)}
                                      - {{(PEND_W-1){1'b0}}, wr && wb_rd == 5'(i) && cnt[i] != '0};
      if (wr && cnt[wb_rd] == '0 && !flush) pend_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard-driven checks of bypass, busy tracking, saturation, flush and reset
module tb_regfile_scoreboard;
  logic clk = 0, reset = 1;
  logic [4:0] rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic [63:0] rs1_data, rs2_data, wb_data;
  logic rs1_busy, rs2_busy, issue_valid, issue_en_rd, issue_ready;
  logic wb_valid, wb_en_rd, flush, pend_err;
  logic [63:0] a [8];
  int errors = 0, checks = 0;
  typedef struct {int sel; string tag; logic [63:0] val;} exp_t;
  exp_t q[$];
  localparam logic [63:0] SP = 64'h7FFF_F000;

  regfile_scoreboard #(.STACK_TOP(SP), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_en_rd(issue_en_rd), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_en_rd(wb_en_rd), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
    .pend_err(pend_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      0: return rs1_data;
      1: return rs2_data;
      2: return {63'd0, rs1_busy};
      3: return {63'd0, rs2_busy};
      4: return {63'd0, issue_ready};
      5: return {63'd0, pend_err};
      default: return a[sel-6];
    endcase
  endfunction

  task automatic expect_val(input int sel, input string tag, input logic [63:0] val);
    q.push_back('{sel, tag, val});
  endtask

  task automatic idle();
    {issue_valid, issue_en_rd, wb_valid, wb_en_rd, flush} = '0;
    {rs1_addr, rs2_addr, issue_rd, wb_rd} = '0;
    wb_data = '0;
  endtask

  task automatic iss(input logic [4:0] rd);
    issue_valid = 1; issue_en_rd = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] d);
    wb_valid = 1; wb_en_rd = 1; wb_rd = rd; wb_data = d;
  endtask

  // sample mid-cycle, retire every pending expectation, then advance past the edge
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, probe(e.sel), e.val);
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    reset = 0;
    rs1_addr = 2; rs2_addr = 10;
    expect_val(0, "rst_sp", SP); expect_val(1, "rst_x10", 0);
    expect_val(2, "rst_b1", 0); expect_val(3, "rst_b2", 0);
    expect_val(5, "rst_perr", 0); expect_val(4, "rst_rdy", 1);
    for (int i = 0; i < 8; i++) expect_val(6 + i, $sformatf("rst_a%0d", i), 0);
    cyc();
    iss(5); expect_val(4, "iss5_rdy", 1); cyc();
    rs1_addr = 5; expect_val(2, "x5_busy", 1); cyc();
    rs1_addr = 5; wb(5, 64'hDEAD_BEEF);
    expect_val(0, "x5_bypass", 64'hDEAD_BEEF); expect_val(2, "x5_bypass_busy", 0); cyc();
    rs1_addr = 5; expect_val(0, "x5_reg", 64'hDEAD_BEEF); expect_val(2, "x5_idle_busy", 0); cyc();
    wb(0, 64'h1234); iss(0);
    expect_val(0, "x0_wr", 0); expect_val(2, "x0_busy", 0); expect_val(4, "x0_rdy", 1); cyc();
    expect_val(0, "x0_rd", 0); expect_val(2, "x0_busy2", 0); expect_val(5, "x0_perr", 0); cyc();
    for (int i = 0; i < 3; i++) begin
      iss(7); expect_val(4, $sformatf("x7_iss%0d", i), 1); cyc();
    end
    iss(7); rs1_addr = 7;
    expect_val(4, "x7_sat_rdy", 0); expect_val(2, "x7_sat_busy", 1); cyc();
    iss(7); wb(7, 64'h70); rs1_addr = 7;
    expect_val(4, "x7_swap_rdy", 1); expect_val(2, "x7_swap_busy", 1); expect_val(0, "x7_swap_data", 64'h70); cyc();
    wb(7, 64'h71); rs1_addr = 7; expect_val(2, "x7_ret1_busy", 1); cyc();
    wb(7, 64'h72); rs1_addr = 7; expect_val(2, "x7_ret2_busy", 1); cyc();
    wb(7, 64'h73); rs1_addr = 7; expect_val(2, "x7_ret3_busy", 0); cyc();
    rs1_addr = 7; expect_val(2, "x7_drained", 0); expect_val(0, "x7_data", 64'h73); expect_val(5, "x7_perr", 0); cyc();
    iss(12); cyc();
    iss(12); cyc();
    iss(11); cyc();
    flush = 1; wb(11, 64'hABC); iss(12); rs1_addr = 11; rs2_addr = 12;
    expect_val(0, "fl_byp", 64'hABC); expect_val(2, "fl_b11", 0); expect_val(3, "fl_b12", 1); cyc();
    rs1_addr = 11; rs2_addr = 12;
    expect_val(0, "fl_x11", 64'hABC); expect_val(2, "fl_b11_after", 0);
    expect_val(3, "fl_b12_after", 0); expect_val(5, "fl_perr", 0); cyc();
    wb(12, 64'h5); expect_val(5, "perr_before", 0); cyc();
    rs2_addr = 12; expect_val(5, "perr_set", 1); expect_val(3, "perr_b12", 0); cyc();
    wb(17, 64'd93); expect_val(13, "a7_same", 0); cyc();
    wb(10, 64'h41); expect_val(13, "a7_next", 64'd93); expect_val(6, "a0_same", 0); cyc();
    expect_val(6, "a0_next", 64'h41); expect_val(13, "a7_hold", 64'd93); expect_val(5, "perr_sticky", 1); cyc();
    iss(3); cyc();
    reset = 1; wb(17, 64'h5); iss(4); cyc();
    reset = 0; rs1_addr = 3; rs2_addr = 4;
    expect_val(2, "mrst_b3", 0); expect_val(3, "mrst_b4", 0); expect_val(6, "mrst_a0", 0);
    expect_val(13, "mrst_a7", 0); expect_val(5, "mrst_perr", 0); cyc();
    rs1_addr = 2; rs2_addr = 17;
    expect_val(0, "mrst_sp", SP); expect_val(1, "mrst_x17", 0); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
